// File: rtl/dac_spi_frame_receiver.sv
// dac_spi_frame_receiver
//
// Responder-side decoder for the AD5662 DAC serial interface. The three DAC
// pins are oversampled on state_clk, each 24-bit frame is shifted in MSB
// first, and a complete frame is committed as control bits, power-down mode
// and a 16-bit DAC code. Aborted frames and frames with extra clocks are
// flagged as frame errors and counted.
//
// Parameters
//   SYNC_STAGES  synchronizer depth (>= 2), identical for all three inputs
//   FRAME_BITS   SCLK falling edges that make up one complete frame
//
// Ports
//   state_clk    sampling clock, rising edge
//   reset        synchronous, active-high reset
//   spi_sync     DAC_SYNC pin, active-low frame enable (asynchronous)
//   spi_sclk     DAC_SCLK pin (asynchronous)
//   spi_din      DAC_DIN pin (asynchronous)
//   dac_word     last committed data field, frame bits 15:0
//   pd_mode      last committed power-down mode, frame bits 17:16
//   ctrl_dc      last committed don't-care bits, frame bits 23:18
//   word_valid   one-cycle pulse when a word commits
//   frame_error  one-cycle pulse on an aborted or overrun frame
//   busy         high while a frame is being received or has completed
//   frame_count  committed frames, wraps
//   error_count  frame errors, saturates at 8'hFF

module dac_spi_frame_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 24
) (
  input  logic        state_clk,
  input  logic        reset,
  input  logic        spi_sync,
  input  logic        spi_sclk,
  input  logic        spi_din,
  output logic [15:0] dac_word,
  output logic [1:0]  pd_mode,
  output logic [5:0]  ctrl_dc,
  output logic        word_valid,
  output logic        frame_error,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  error_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS);

  state_t state;
  state_t state_next;

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic [SYNC_STAGES-1:0] sclk_pipe;
  logic [SYNC_STAGES-1:0] din_pipe;
  logic                   sync_dly;
  logic                   sclk_dly;

  logic sync_s;
  logic sclk_s;
  logic din_s;
  logic sync_fall;
  logic sync_rise;
  logic sclk_fall;

  logic [4:0]  bit_cnt;
  logic [4:0]  bit_cnt_inc;
  logic [23:0] shift_reg;
  logic [23:0] shift_next;
  logic        overrun;

  logic start_frame;
  logic shift_bit;
  logic commit;
  logic flag_error;
  logic set_overrun;

  // Synchronizer chains for the three asynchronous pins, plus one extra delay
  // flop on SYNC and SCLK so their edges can be detected. Everything resets to
  // zero: a SYNC that is already low when reset releases therefore never looks
  // like a falling edge, so a frame caught mid-flight by reset is skipped.
  always_ff @(posedge state_clk) begin
    if (reset) begin
      sync_pipe <= '0;
      sclk_pipe <= '0;
      din_pipe  <= '0;
      sync_dly  <= 1'b0;
      sclk_dly  <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], spi_sync};
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], spi_sclk};
      din_pipe  <= {din_pipe[SYNC_STAGES-2:0], spi_din};
      sync_dly  <= sync_pipe[SYNC_STAGES-1];
      sclk_dly  <= sclk_pipe[SYNC_STAGES-1];
    end
  end

  // Edge strobes from the last synchronizer stage and its delayed copy. DIN is
  // taken from the same stage as SCLK so the bit lines up with its clock edge.
  always_comb begin
    sync_s      = sync_pipe[SYNC_STAGES-1];
    sclk_s      = sclk_pipe[SYNC_STAGES-1];
    din_s       = din_pipe[SYNC_STAGES-1];
    sync_fall   = sync_dly & ~sync_s;
    sync_rise   = ~sync_dly & sync_s;
    sclk_fall   = sclk_dly & ~sclk_s;
    bit_cnt_inc = bit_cnt + 5'd1;
    shift_next  = {shift_reg[22:0], din_s};
  end

  // State register for the frame FSM.
  always_ff @(posedge state_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and datapath strobes. A SYNC rise is always examined
  // before an SCLK fall, so when both show up in one cycle the clock edge is
  // dropped. A SYNC rise before any bit arrived is a harmless empty frame.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    shift_bit   = 1'b0;
    commit      = 1'b0;
    flag_error  = 1'b0;
    set_overrun = 1'b0;
    case (state)
      IDLE: begin
        if (sync_fall) begin
          state_next  = SHIFT;
          start_frame = 1'b1;
        end
      end
      SHIFT: begin
        if (sync_rise) begin
          state_next = IDLE;
          if (bit_cnt != 5'd0) begin
            flag_error = 1'b1;
          end
        end else if (sclk_fall) begin
          shift_bit = 1'b1;
          if (bit_cnt_inc == FRAME_LAST) begin
            commit     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (sync_rise) begin
          state_next = IDLE;
          if (overrun) begin
            flag_error = 1'b1;
          end
        end else if (sclk_fall) begin
          set_overrun = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: busy follows the registered state, so it rises the cycle
  // after the SYNC fall is seen and drops the cycle after the SYNC rise.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: shift register, bit counter, overrun flag, committed fields and
  // the statistics counters. The committed fields come up at DAC midscale and
  // only change on a full frame, so aborted frames leave them untouched.
  always_ff @(posedge state_clk) begin
    if (reset) begin
      bit_cnt     <= 5'd0;
      shift_reg   <= 24'd0;
      overrun     <= 1'b0;
      dac_word    <= 16'h8000;
      pd_mode     <= 2'd0;
      ctrl_dc     <= 6'd0;
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= 16'd0;
      error_count <= 8'd0;
    end else begin
      word_valid  <= commit;
      frame_error <= flag_error;

      if (start_frame) begin
        bit_cnt   <= 5'd0;
        shift_reg <= 24'd0;
      end else if (shift_bit) begin
        bit_cnt   <= bit_cnt_inc;
        shift_reg <= shift_next;
      end

      if (state_next != DONE) begin
        overrun <= 1'b0;
      end else if (set_overrun) begin
        overrun <= 1'b1;
      end

      if (commit) begin
        {ctrl_dc, pd_mode, dac_word} <= shift_next;
        frame_count <= frame_count + 16'd1;
      end

      if (flag_error && (error_count != 8'hFF)) begin
        error_count <= error_count + 8'd1;
      end
    end
  end

endmodule
